// File: rtl/t05_sram_arbiter.sv
// t05_sram_arbiter: N-client arbiter onto one request/acknowledge SRAM port.
// Each client gets a one-cycle grant pulse when its request is latched and a
// one-cycle done pulse (with error flag) when the access ends. Acks may take
// any number of cycles; an optional timeout aborts a stuck access.
module t05_sram_arbiter #(
    parameter int N_CLIENTS = 5,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int ARB_MODE  = 1,
    parameter int TIMEOUT   = 64,
    localparam int IDX_W    = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CLIENTS-1:0]        cl_req,
    input  logic [N_CLIENTS-1:0]        cl_we,
    input  logic [N_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [N_CLIENTS*DATA_W-1:0] cl_wdata,
    output logic [N_CLIENTS-1:0]        cl_gnt,
    output logic [N_CLIENTS-1:0]        cl_done,
    output logic                        cl_err,
    output logic [DATA_W-1:0]           cl_rdata,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        busy_o,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ack,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    logic [1:0]                         state;
    logic [IDX_W-1:0]                   rr_ptr;
    logic [CNT_W-1:0]                   cnt;
    logic [CNT_W-1:0]                   cnt_inc;
    logic                               timed_out;

    logic [N_CLIENTS-1:0][ADDR_W-1:0]   addr_arr;
    logic [N_CLIENTS-1:0][DATA_W-1:0]   wdata_arr;
    req_t [N_CLIENTS-1:0]               lane_req;
    req_t                               sel_req;

    logic [IDX_W-1:0]                   win;
    logic                               win_vld;
    logic [N_CLIENTS-1:0]               win_oh;
    logic [N_CLIENTS-1:0]               cur_oh;

    // flattened client buses share the packed-array layout (client i at i*W)
    assign addr_arr  = cl_addr;
    assign wdata_arr = cl_wdata;

    // pick the winner: lowest index, or first requester after the RR pointer
    always_comb begin
        logic [IDX_W-1:0] ci;
        int               c;
        win     = '0;
        win_vld = 1'b0;
        ci      = '0;
        c       = 0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            if (ARB_MODE == 0) begin
                c = k;
            end else begin
                c = int'(rr_ptr) + k + 1;
                if (c >= N_CLIENTS) c = c - N_CLIENTS;
            end
            ci = IDX_W'(c);
            if (!win_vld && cl_req[ci]) begin
                win     = ci;
                win_vld = 1'b1;
            end
        end
    end

    // one-hot forms of the new winner and of the client owning the access
    always_comb begin
        win_oh         = '0;
        win_oh[win]    = win_vld;
        cur_oh         = '0;
        cur_oh[grant_idx] = 1'b1;
    end

    // per-client gating so the request mux becomes a flat AND-OR
    for (genvar g = 0; g < N_CLIENTS; g++) begin : g_lane
        assign lane_req[g] = win_oh[g]
                           ? req_t'{we: cl_we[g], addr: addr_arr[g], wdata: wdata_arr[g]}
                           : req_t'('0);
    end

    // OR-reduce the gated lanes into the winning request
    always_comb begin
        logic [IDX_W-1:0] ii;
        sel_req = '0;
        ii      = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            ii      = IDX_W'(i);
            sel_req = sel_req | lane_req[ii];
        end
    end

    // timeout fires when this BUSY cycle would bring the count to TIMEOUT
    always_comb begin
        cnt_inc   = cnt + 1'b1;
        timed_out = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
    end

    // IDLE -> BUSY -> DONE sequencer; every output is a register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= IDX_W'(N_CLIENTS - 1);
            cnt       <= '0;
            cl_gnt    <= '0;
            cl_done   <= '0;
            cl_err    <= 1'b0;
            cl_rdata  <= '0;
            grant_idx <= '0;
            busy_o    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cl_gnt  <= '0;
            cl_done <= '0;
            cl_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        state     <= ST_BUSY;
                        busy_o    <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= sel_req.we;
                        mem_addr  <= sel_req.addr;
                        mem_wdata <= sel_req.wdata;
                        cl_gnt    <= win_oh;
                        grant_idx <= win;
                        if (ARB_MODE != 0) rr_ptr <= win;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt_inc;
                    // ack takes precedence over a timeout on the same cycle
                    if (mem_ack) begin
                        state   <= ST_DONE;
                        mem_req <= 1'b0;
                        cl_done <= cur_oh;
                        if (!mem_we) cl_rdata <= mem_rdata;
                    end else if (timed_out) begin
                        state    <= ST_DONE;
                        mem_req  <= 1'b0;
                        cl_done  <= cur_oh;
                        cl_err   <= 1'b1;
                        cl_rdata <= '0;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                    cnt    <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    busy_o  <= 1'b0;
                    mem_req <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Bench for t05_sram_arbiter: a round-robin/timeout-8 instance driven by a
// programmable SRAM responder, plus a fixed-priority twin sharing the client
// inputs with an always-immediate responder.
module tb_t05_sram_arbiter;
    localparam int N  = 5;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    cl_req = '0;
    logic [N-1:0]    cl_we = '0;
    logic [N*AW-1:0] cl_addr = '0;
    logic [N*DW-1:0] cl_wdata = '0;

    logic [N-1:0]    cl_gnt, cl_done;
    logic            cl_err, busy_o, mem_req, mem_we;
    logic [DW-1:0]   cl_rdata, mem_wdata;
    logic [IW-1:0]   grant_idx;
    logic [AW-1:0]   mem_addr;
    logic            mem_ack = 1'b0;
    logic [DW-1:0]   mem_rdata = '0;

    logic [N-1:0]    cl_gnt_f, cl_done_f;
    logic            cl_err_f, busy_f, mem_req_f, mem_we_f;
    logic [DW-1:0]   cl_rdata_f, mem_wdata_f;
    logic [IW-1:0]   grant_idx_f;
    logic [AW-1:0]   mem_addr_f;
    logic            mem_ack_f;
    logic [DW-1:0]   mem_rdata_f;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [N-1:0]  oh;
        logic          err;
        logic [DW-1:0] rd;
    } exp_t;
    exp_t exp_q[$];
    int   gnt_q[$];

    int            ack_delay  = 1;
    int            req_cycles = 0;
    bit            stray_ack  = 1'b0;
    logic [DW-1:0] ack_data   = '0;

    t05_sram_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr),
        .cl_wdata(cl_wdata), .cl_gnt(cl_gnt), .cl_done(cl_done), .cl_err(cl_err),
        .cl_rdata(cl_rdata), .grant_idx(grant_idx), .busy_o(busy_o), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    t05_sram_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(8)) dut_fp (
        .clk(clk), .rst(rst), .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr),
        .cl_wdata(cl_wdata), .cl_gnt(cl_gnt_f), .cl_done(cl_done_f), .cl_err(cl_err_f),
        .cl_rdata(cl_rdata_f), .grant_idx(grant_idx_f), .busy_o(busy_f), .mem_req(mem_req_f),
        .mem_we(mem_we_f), .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f), .mem_ack(mem_ack_f),
        .mem_rdata(mem_rdata_f)
    );

    always #5 clk = ~clk;

    assign mem_ack_f   = mem_req_f;
    assign mem_rdata_f = '0;

    // SRAM model: ack on the ack_delay-th cycle of mem_req (0 = never)
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            req_cycles = req_cycles + 1;
            mem_ack    = (ack_delay != 0) && (req_cycles == ack_delay);
        end else begin
            req_cycles = 0;
            mem_ack    = stray_ack;
        end
        mem_rdata = ack_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input int c, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cl_req[c]             = 1'b1;
        cl_we[c]              = we;
        cl_addr[c*AW +: AW]   = a;
        cl_wdata[c*DW +: DW]  = d;
    endtask

    task automatic wait_gnt(input int max, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (cl_gnt != '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (cl_done != '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        bit   ok;
        exp_t e;
        rst = 1'b0; ack_delay = 1; ack_data = 128'h55;
        for (int c = 0; c < N; c++) drive_req(c, 1'b0, AW'(c), '0);
        repeat (5) @(negedge clk);
        n_checks++; if ({cl_gnt, cl_done, cl_err, busy_o, mem_req, mem_we} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0", {cl_gnt, cl_done, cl_err, busy_o, mem_req, mem_we}); end
        n_checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++; $display("FAIL reset_mem: got addr %0h wdata %0h want 0", mem_addr, mem_wdata); end
        n_checks++; if (cl_rdata !== '0 || grant_idx !== '0) begin
            n_fail++; $display("FAIL reset_rdata_idx: got %0h/%0d want 0/0", cl_rdata, grant_idx); end
        rst = 1'b1;
        exp_q.push_back('{oh: 5'b00001, err: 1'b0, rd: 128'h55});
        @(negedge clk);
        n_checks++; if (cl_gnt !== 5'b00001 || grant_idx !== 3'd0 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_gnt: got gnt %b idx %0d busy %b want 00001/0/1", cl_gnt, grant_idx, busy_o); end
        cl_req = '0;
        wait_done(10, ok);
        e = exp_q.pop_front();
        n_checks++; if (!ok || cl_done !== e.oh || cl_err !== e.err || cl_rdata !== e.rd) begin
            n_fail++; $display("FAIL reset_done: got done %b err %b rd %0h want %b/%b/%0h", cl_done, cl_err, cl_rdata, e.oh, e.err, e.rd); end
    endtask

    task automatic test_single_write();
        int   lat;
        exp_t e;
        @(negedge clk);
        ack_delay = 2;
        drive_req(0, 1'b1, 32'd3, 128'd17);
        exp_q.push_back('{oh: 5'b00001, err: 1'b0, rd: 128'h55});
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++; if (cl_gnt !== 5'b00001 || mem_req !== 1'b1) begin
                    n_fail++; $display("FAIL wr_gnt: got gnt %b req %b want 00001/1", cl_gnt, mem_req); end
                n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd3 || mem_wdata !== 128'd17) begin
                    n_fail++; $display("FAIL wr_mem: got we %b addr %0d wdata %0d want 1/3/17", mem_we, mem_addr, mem_wdata); end
                cl_req = '0;
            end
            if (cl_done != '0) begin lat = k; break; end
        end
        n_checks++; if (lat !== 3) begin
            n_fail++; $display("FAIL wr_latency: got %0d want 3", lat); end
        e = exp_q.pop_front();
        n_checks++; if (cl_done !== e.oh || cl_err !== e.err || cl_rdata !== e.rd) begin
            n_fail++; $display("FAIL wr_done: got done %b err %b rd %0h want %b/%b/%0h", cl_done, cl_err, cl_rdata, e.oh, e.err, e.rd); end
    endtask

    task automatic test_slow_read();
        bit            ok, seen;
        int            busy_cnt;
        logic [N-1:0]  d;
        logic          er;
        logic [DW-1:0] rd;
        exp_t          e;
        @(negedge clk);
        ack_delay = 4; ack_data = 128'd345;
        drive_req(4, 1'b0, 32'd11, '0);
        exp_q.push_back('{oh: 5'b10000, err: 1'b0, rd: 128'd345});
        wait_gnt(10, ok);
        cl_req = '0;
        n_checks++; if (!ok || grant_idx !== 3'd4 || mem_addr !== 32'd11 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL rd_gnt: got ok %b idx %0d addr %0d we %b want 1/4/11/0", ok, grant_idx, mem_addr, mem_we); end
        busy_cnt = busy_o ? 1 : 0;
        seen = 1'b0; d = '0; er = 1'b0; rd = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy_o) break;
            busy_cnt++;
            if (cl_done != '0) begin seen = 1'b1; d = cl_done; er = cl_err; rd = cl_rdata; end
        end
        n_checks++; if (busy_cnt !== 5) begin
            n_fail++; $display("FAIL rd_busy_len: got %0d want 5", busy_cnt); end
        e = exp_q.pop_front();
        n_checks++; if (!seen || d !== e.oh || er !== e.err || rd !== e.rd) begin
            n_fail++; $display("FAIL rd_done: got seen %b done %b err %b rd %0d want %b/%b/%0d", seen, d, er, rd, e.oh, e.err, e.rd); end
    endtask

    task automatic test_round_robin();
        bit           ok;
        int           g;
        logic [N-1:0] oh;
        exp_t         e;
        @(negedge clk);
        ack_delay = 1; ack_data = 128'hABC;
        for (int c = 1; c <= 3; c++) drive_req(c, 1'b0, AW'(20 + c), '0);
        gnt_q = '{1, 2, 3, 1};
        foreach (gnt_q[i]) begin
            oh = '0; oh[gnt_q[i]] = 1'b1;
            exp_q.push_back('{oh: oh, err: 1'b0, rd: 128'hABC});
        end
        for (int it = 0; it < 4; it++) begin
            wait_gnt(10, ok);
            g = gnt_q.pop_front();
            oh = '0; oh[g] = 1'b1;
            n_checks++; if (!ok || grant_idx !== IW'(g) || cl_gnt !== oh) begin
                n_fail++; $display("FAIL rr_order[%0d]: got idx %0d gnt %b want %0d", it, grant_idx, cl_gnt, g); end
            if (it < 3) begin
                n_checks++; if (grant_idx_f !== 3'd1 || cl_gnt_f !== 5'b00010) begin
                    n_fail++; $display("FAIL fp_order[%0d]: got idx %0d gnt %b want 1/00010", it, grant_idx_f, cl_gnt_f); end
            end
            if (it == 3) cl_req = '0;
            wait_done(10, ok);
            e = exp_q.pop_front();
            n_checks++; if (!ok || cl_done !== e.oh || cl_err !== e.err || cl_rdata !== e.rd) begin
                n_fail++; $display("FAIL rr_done[%0d]: got done %b err %b rd %0h want %b/%b/%0h", it, cl_done, cl_err, cl_rdata, e.oh, e.err, e.rd); end
        end
    endtask

    task automatic test_timeout();
        bit   ok;
        int   req_cnt;
        exp_t e;
        repeat (2) @(negedge clk);
        ack_delay = 0;
        drive_req(2, 1'b0, 32'd40, '0);
        exp_q.push_back('{oh: 5'b00100, err: 1'b1, rd: '0});
        wait_gnt(10, ok);
        cl_req = '0;
        req_cnt = mem_req ? 1 : 0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cl_done != '0) begin ok = 1'b1; break; end
            if (mem_req) req_cnt++;
        end
        n_checks++; if (req_cnt !== 8) begin
            n_fail++; $display("FAIL to_req_len: got %0d want 8", req_cnt); end
        e = exp_q.pop_front();
        n_checks++; if (!ok || cl_done !== e.oh || cl_err !== e.err || cl_rdata !== e.rd || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL to_done: got done %b err %b rd %0h req %b want %b/%b/%0h/0", cl_done, cl_err, cl_rdata, mem_req, e.oh, e.err, e.rd); end
        @(negedge clk);
        stray_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if ({busy_o, mem_req, cl_done, cl_err} !== '0) begin
                n_fail++; $display("FAIL stray_ack[%0d]: got %b want 0", k, {busy_o, mem_req, cl_done, cl_err}); end
        end
        stray_ack = 1'b0;
    endtask

    task automatic test_ack_at_timeout();
        bit   ok;
        exp_t e;
        @(negedge clk);
        ack_delay = 8; ack_data = 128'h1234;
        drive_req(1, 1'b0, 32'd60, '0);
        exp_q.push_back('{oh: 5'b00010, err: 1'b0, rd: 128'h1234});
        wait_gnt(10, ok);
        cl_req = '0;
        wait_done(20, ok);
        e = exp_q.pop_front();
        n_checks++; if (!ok || cl_done !== e.oh || cl_err !== e.err || cl_rdata !== e.rd) begin
            n_fail++; $display("FAIL ack_vs_timeout: got done %b err %b rd %0h want %b/%b/%0h", cl_done, cl_err, cl_rdata, e.oh, e.err, e.rd); end
    endtask

    task automatic test_reset_mid_busy();
        bit   ok;
        exp_t e;
        repeat (2) @(negedge clk);
        ack_delay = 0;
        drive_req(3, 1'b0, 32'd50, '0);
        wait_gnt(10, ok);
        cl_req = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_busy_pre: got req %b busy %b want 1/1", mem_req, busy_o); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++; if ({mem_req, busy_o, cl_gnt, cl_done, grant_idx} !== '0 || cl_rdata !== '0) begin
            n_fail++; $display("FAIL mid_busy_rst: got %b rd %0h want 0", {mem_req, busy_o, cl_gnt, cl_done, grant_idx}, cl_rdata); end
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (cl_done != '0 || busy_o) ok = 1'b1;
        end
        n_checks++; if (ok !== 1'b0) begin
            n_fail++; $display("FAIL mid_busy_quiet: got activity %b want 0", ok); end
        ack_delay = 1; ack_data = 128'h77;
        drive_req(3, 1'b0, 32'd51, '0);
        exp_q.push_back('{oh: 5'b01000, err: 1'b0, rd: 128'h77});
        wait_gnt(10, ok);
        cl_req = '0;
        n_checks++; if (!ok || grant_idx !== 3'd3 || mem_addr !== 32'd51) begin
            n_fail++; $display("FAIL mid_busy_regnt: got ok %b idx %0d addr %0d want 1/3/51", ok, grant_idx, mem_addr); end
        wait_done(10, ok);
        e = exp_q.pop_front();
        n_checks++; if (!ok || cl_done !== e.oh || cl_err !== e.err || cl_rdata !== e.rd) begin
            n_fail++; $display("FAIL mid_busy_done: got done %b err %b rd %0h want %b/%b/%0h", cl_done, cl_err, cl_rdata, e.oh, e.err, e.rd); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_slow_read();
        test_round_robin();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_busy();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
